pushbutton_debouncer: RTL and testbench
=======================================

// Module: pushbutton_debouncer
// PURPOSE
//  Synchronises and debounces raw board pushbuttons; feeds clean levels to the Pushbuttons PIO in_port.
//  Sits between the KEY[] pins and the PIO, so PIO edge capture fires once per physical press.
//  Also emits one-cycle press/release strobes for hardware consumers that bypass the CPU.
// PARAMETERS
//  NUM_BTN         4       number of buttons/channels
//  ACTIVE_LOW      1       1: pressed = 0 on pin (DE-board KEYs); 0: pressed = 1
//  TICK_DIV        50000   clk cycles per debounce tick (1 ms @ 50 MHz); >= 2
//  DEBOUNCE_TICKS  20      consecutive ticks of a differing input needed to accept a change; >= 2
//  LONG_TICKS      1000    ticks held pressed before long_press (PB_LONGPRESS_EN only)
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous, active-low reset
//  btn_raw      in   NUM_BTN  raw asynchronous pin levels
//  btn_level    out  NUM_BTN  debounced level, same polarity as btn_raw; to PIO in_port
//  btn_press    out  NUM_BTN  1-cycle pulse when debounced level enters pressed state
//  btn_release  out  NUM_BTN  1-cycle pulse when debounced level enters released state
//  long_press   out  NUM_BTN  1-cycle pulse after hold of LONG_TICKS ticks (0 if macro off)
// BEHAVIOUR
//  - Reset: sync FFs, btn_level = released level (ACTIVE_LOW ? all 1 : all 0); counters 0; all pulses 0.
//    No press/release pulse and no PIO falling edge is generated on reset exit.
//  - Sync: 2-FF synchroniser per bit; sync = value two clk edges after pin change.
//  - Tick: shared prescaler counts 0..TICK_DIV-1, tick = 1 for one cycle at TICK_DIV-1, then wraps to 0.
//  - Per-channel cnt (width clog2(DEBOUNCE_TICKS)):
//    * any cycle with sync == btn_level: cnt <= 0 (a bounce restarts the window)
//    * tick with sync != btn_level and cnt <  DEBOUNCE_TICKS-1: cnt++
//    * tick with sync != btn_level and cnt == DEBOUNCE_TICKS-1: btn_level <= sync, cnt <= 0,
//      and btn_press or btn_release is asserted in the same registered cycle as the level update
//  - Latency from stable sync change to btn_level change: (DEBOUNCE_TICKS-1)*TICK_DIV+1 to DEBOUNCE_TICKS*TICK_DIV cycles.
//  - btn_press and btn_release are never both high on one channel; channels are independent and may pulse together.
//  - All outputs registered; reset mid-count discards partial counts and forces the released level.
// CONFIGURATION
//  PB_LONGPRESS_EN defined: per-channel hold counter, cleared on press, counts ticks while pressed;
//    long_press pulses once when count reaches LONG_TICKS-1 and saturates; cleared on release.
//  PB_LONGPRESS_EN undefined: no hold counter; long_press tied to 0.
// STRUCTURE
//  pb_debounce_pkg: state encodings, reset-level function, clog2-based width constants.
//  Sub-module pb_debounce_chan: one channel (sync, cnt, level, pulses, optional hold counter).
//  Top: prescaler plus a generate loop of NUM_BTN pb_debounce_chan instances.
// TESTING  (bench params: NUM_BTN=4, ACTIVE_LOW=1, TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=5)
//  1. Reset release, btn_raw=4'hF -> btn_level=4'hF, no pulses for 100 cycles.
//  2. btn_raw[0] 1->0, held -> btn_level[0]=0 within 9..14 cycles; btn_press[0] exactly 1 cycle.
//  3. btn_raw[1] toggles every 5 cycles for 60 cycles, then 0 -> no pulse during toggling; one press after settling.
//  4. btn_raw[2],[3] released 0->1 on same cycle -> btn_release=4'b1100 in one cycle, btn_level=4'hF.
//  5. reset_n low mid-count (cnt=1) on ch0 -> btn_level[0]=1, cnt=0, no pulse after reset exit.
//  6. PB_LONGPRESS_EN on: hold ch0 pressed 40 cycles -> exactly one long_press[0]; macro off -> always 0.

Source files
------------

// File: rtl/pb_debounce_pkg.sv
// Shared types and width helpers for the pushbutton debouncer.
// Optional long-press detection is enabled by defining PB_LONGPRESS_EN.
package pb_debounce_pkg;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    localparam int unsigned MIN_CNT_W = 1;

    // Pin level that means "not pressed" for the given polarity.
    function automatic logic released_level(input bit active_low);
        return active_low;
    endfunction

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? MIN_CNT_W : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, tick-qualified stability counter,
// registered level and press/release strobes; hold counter when PB_LONGPRESS_EN is defined.
module pb_debounce_chan
    import pb_debounce_pkg::*;
#(
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = 20
`ifdef PB_LONGPRESS_EN
    ,
    parameter int unsigned LONG_TICKS     = 1000
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic long_press
);

    localparam logic                REL_LVL  = released_level(ACTIVE_LOW);
    localparam logic                PRS_LVL  = ~REL_LVL;
    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             sync_pressed;
    logic             differs;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        sync_pressed = (sync2_q == PRS_LVL);
        differs      = (sync_pressed != (state_q == BTN_PRESSED));

        // Any agreeing cycle restarts the window, so bounces never accumulate.
        if (!differs) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (sync_pressed) begin
                    state_d = BTN_PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d   = BTN_RELEASED;
                    release_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= REL_LVL;
            sync2_q   <= REL_LVL;
            state_q   <= BTN_RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = (state_q == BTN_PRESSED) ? PRS_LVL : REL_LVL;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef PB_LONGPRESS_EN
    localparam int unsigned      HOLD_W    = cnt_width(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_TICKS - 2);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Counts ticks while held; saturates so the strobe fires only once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d || state_q != BTN_PRESSED) begin
            hold_d = '0;
        end else if (tick && hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_PRE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_debouncer.sv
// Debounces NUM_BTN raw pushbuttons for a PIO in_port and emits press/release strobes.
// Define PB_LONGPRESS_EN to enable the long_press strobes; otherwise they are tied low.
module pushbutton_debouncer
    import pb_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN        = 4,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned LONG_TICKS     = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] long_press
);

    localparam int unsigned      DIV_W    = cnt_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // One prescaler shared by all channels keeps their tick phases aligned.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        pb_debounce_chan #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
`ifdef PB_LONGPRESS_EN
            ,
            .LONG_TICKS     (LONG_TICKS)
`endif
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick        (tick),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .long_press  (long_press[i])
        );
    end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Randomised and directed bench for pushbutton_debouncer against a cycle-level behavioural model.
// Build with PB_LONGPRESS_EN defined to cover the long-press strobes.
module tb_pushbutton_debouncer;

    localparam int NUM_BTN        = 4;
    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int LONG_TICKS     = 5;
`ifdef PB_LONGPRESS_EN
    localparam int EXP_LONG = 1;
`else
    localparam int EXP_LONG = 0;
`endif

    // ---------------- clock / reset ----------------
    logic               clk     = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_BTN-1:0] btn_raw = 4'hF;
    logic [NUM_BTN-1:0] btn_level, btn_press, btn_release, long_press;

    always #5 clk = ~clk;

    pushbutton_debouncer #(
        .NUM_BTN        (NUM_BTN),
        .ACTIVE_LOW     (1'b1),
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .LONG_TICKS     (LONG_TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .long_press  (long_press)
    );

    // ---------------- scoreboard ----------------
    int assert_cnt = 0;
    int fail_cnt   = 0;
    logic [15:0] exp_q[$];

    int cnt_press[NUM_BTN];
    int cnt_rel[NUM_BTN];
    int cnt_long[NUM_BTN];
    int cnt_rel_pair;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pin history feeds a two-edge delay; a change is accepted after DEBOUNCE_TICKS
    // consecutive ticks of disagreement, ticks falling every TICK_DIV-th edge since reset.
    logic [NUM_BTN-1:0] m_s1 = 4'hF, m_s2 = 4'hF, m_lvl = 4'hF;
    int m_run[NUM_BTN];
    int m_hold[NUM_BTN];
    int m_k = 0;

    task automatic model_step();
        logic [NUM_BTN-1:0] prs, rel, lp;
        bit tk;
        prs = '0; rel = '0; lp = '0;
        if (!reset_n) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_k = 0;
            for (int c = 0; c < NUM_BTN; c++) begin
                m_run[c] = 0; m_hold[c] = 0;
            end
        end else begin
            tk = ((m_k % TICK_DIV) == TICK_DIV - 1);
            for (int c = 0; c < NUM_BTN; c++) begin
                bit was_pressed;
                was_pressed = (m_lvl[c] == 1'b0);
                if (m_s2[c] == m_lvl[c]) m_run[c] = 0;
                else if (tk) begin
                    m_run[c]++;
                    if (m_run[c] == DEBOUNCE_TICKS) begin
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                        if (m_s2[c] == 1'b0) prs[c] = 1'b1; else rel[c] = 1'b1;
                    end
                end
                if (EXP_LONG == 1) begin
                    if (prs[c] || !was_pressed) m_hold[c] = 0;
                    else if (tk && m_hold[c] < LONG_TICKS - 1) begin
                        m_hold[c]++;
                        if (m_hold[c] == LONG_TICKS - 1) lp[c] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_k++;
        end
        exp_q.push_back({lp, rel, prs, m_lvl});
    endtask

    // ---------------- driver ----------------
    task automatic clear_counts();
        for (int c = 0; c < NUM_BTN; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0;
        end
        cnt_rel_pair = 0;
    endtask

    task automatic step();
        logic [15:0] e;
        @(posedge clk);
        #1;
        model_step();
        e = exp_q.pop_front();
        check_eq("level",   32'(btn_level),   32'(e[3:0]));
        check_eq("press",   32'(btn_press),   32'(e[7:4]));
        check_eq("release", 32'(btn_release), 32'(e[11:8]));
        check_eq("long",    32'(long_press),  32'(e[15:12]));
        check_eq("press_and_release", 32'(btn_press & btn_release), 32'd0);
        for (int c = 0; c < NUM_BTN; c++) begin
            cnt_press[c] += int'(btn_press[c]);
            cnt_rel[c]   += int'(btn_release[c]);
            cnt_long[c]  += int'(long_press[c]);
        end
        if (btn_release == 4'b1100) cnt_rel_pair++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int c = 0; c < NUM_BTN; c++) s += cnt_press[c] + cnt_rel[c];
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int latency;
        bit found;

        // 1: reset exit with buttons released
        for (int c = 0; c < NUM_BTN; c++) begin
            m_run[c] = 0; m_hold[c] = 0;
        end
        btn_raw = 4'hF;
        steps(3);
        reset_n = 1'b1;
        clear_counts();
        steps(100);
        check_eq("t1_level", 32'(btn_level), 32'hF);
        check_eq("t1_no_pulses", 32'(total_pulses()), 32'd0);

        // 2: single clean press on ch0
        clear_counts();
        btn_raw[0] = 1'b0;
        latency = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (latency < 0 && btn_level[0] == 1'b0) latency = i;
        end
        check_eq("t2_latency_9_to_14", 32'(latency >= 9 && latency <= 14), 32'd1);
        check_eq("t2_press_count", 32'(cnt_press[0]), 32'd1);

        // 3: bouncing ch1 never settles long enough, then a real press
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) btn_raw[1] = ~btn_raw[1];
            step();
        end
        check_eq("t3_no_pulse_bouncing", 32'(cnt_press[1] + cnt_rel[1]), 32'd0);
        btn_raw[1] = 1'b0;
        steps(20);
        check_eq("t3_press_after_settle", 32'(cnt_press[1]), 32'd1);
        check_eq("t3_level", 32'(btn_level[1]), 32'd0);

        // 4: simultaneous release on ch2/ch3
        btn_raw = 4'hF;
        steps(30);
        btn_raw = 4'b0011;
        steps(30);
        clear_counts();
        btn_raw = 4'hF;
        steps(30);
        check_eq("t4_release_pair_once", 32'(cnt_rel_pair), 32'd1);
        check_eq("t4_release_ch2", 32'(cnt_rel[2]), 32'd1);
        check_eq("t4_level", 32'(btn_level), 32'hF);

        // 5: reset mid-count discards partial window
        btn_raw[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (m_run[0] == 1) found = 1'b1;
        end
        check_eq("t5_reached_cnt1", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_async_level", 32'(btn_level), 32'hF);
        check_eq("t5_async_pulses", 32'(btn_press | btn_release), 32'd0);
        btn_raw = 4'hF;
        steps(3);
        reset_n = 1'b1;
        clear_counts();
        steps(100);
        check_eq("t5_no_pulse_after_reset", 32'(total_pulses()), 32'd0);
        check_eq("t5_level", 32'(btn_level), 32'hF);

        // 6: long hold on ch0
        clear_counts();
        btn_raw[0] = 1'b0;
        steps(40);
        check_eq("t6_long_count", 32'(cnt_long[0]), 32'(EXP_LONG));
        check_eq("t6_long_other", 32'(cnt_long[1] + cnt_long[2] + cnt_long[3]), 32'd0);
        btn_raw[0] = 1'b1;
        steps(20);

        // random: independent noisy channels with occasional long holds
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_BTN; c++) begin
                if ($urandom_range(0, 13) == 0) btn_raw[c] = ~btn_raw[c];
            end
            if ($urandom_range(0, 99) == 0) begin
                steps(int'($urandom_range(10, 40)));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
